// File: rtl/mux_scan_sequencer.sv
// Scan sequencer for an 8:1 multiplexer: steps the select, settles, samples each
// channel into a shadow word, then presents the assembled word on valid/ready.
module mux_scan_sequencer #(
  parameter int SEL_WIDTH     = 3,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    abort,
  input  logic                    mux_out,
  output logic [SEL_WIDTH-1:0]    s,
  output logic [2**SEL_WIDTH-1:0] data,
  output logic                    valid,
  input  logic                    ready,
  output logic                    busy
);

  localparam int N     = 2 ** SEL_WIDTH;
  localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    HOLD   = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [SEL_WIDTH-1:0] s_q, s_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [N-1:0]         shadow_q, shadow_d;
  logic [N-1:0]         data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 busy_q, busy_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      s_q      <= '0;
      cnt_q    <= '0;
      shadow_q <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      s_q      <= s_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    s_d      = s_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    data_d   = data_q;
    valid_d  = valid_q;

    unique case (state_q)
      IDLE: begin
        s_d = '0;
        if (start && !abort) begin
          cnt_d    = CNT_W'(SETTLE_CYCLES);
          shadow_d = '0;
          state_d  = SETTLE;
        end
      end

      SETTLE: begin
        if (abort) begin
          s_d     = '0;
          state_d = IDLE;
        end else if (cnt_q == CNT_W'(1)) begin
          state_d = SAMPLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      SAMPLE: begin
        if (abort) begin
          s_d     = '0;
          state_d = IDLE;
        end else begin
          shadow_d[s_q] = mux_out;
          if (s_q == SEL_WIDTH'(N - 1)) begin
            // Publish the whole word at once so data never shows a partial scan.
            data_d  = shadow_d;
            valid_d = 1'b1;
            state_d = HOLD;
          end else begin
            s_d     = s_q + SEL_WIDTH'(1);
            cnt_d   = CNT_W'(SETTLE_CYCLES);
            state_d = SETTLE;
          end
        end
      end

      HOLD: begin
        if (valid_q && ready) begin
          valid_d = 1'b0;
          s_d     = '0;
          if (start) begin
            cnt_d    = CNT_W'(SETTLE_CYCLES);
            shadow_d = '0;
            state_d  = SETTLE;
          end else begin
            state_d = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase

    // Registered so busy is glitch-free and tracks the state being entered.
    busy_d = (state_d != IDLE);
  end

  assign s     = s_q;
  assign data  = data_q;
  assign valid = valid_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Directed bench for mux_scan_sequencer; the 8:1 multiplexer is modelled inline.
module tb_mux_scan_sequencer;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       abort;
  logic       mux_out;
  logic [2:0] s;
  logic [7:0] data;
  logic       valid;
  logic       ready;
  logic       busy;
  logic [7:0] i_vec;

  int checks;
  int errors;

  mux_scan_sequencer #(.SEL_WIDTH(3), .SETTLE_CYCLES(1)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .abort  (abort),
    .mux_out(mux_out),
    .s      (s),
    .data   (data),
    .valid  (valid),
    .ready  (ready),
    .busy   (busy)
  );

  assign mux_out = i_vec[s];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called just after the edge that sampled start; runs to the valid edge (16).
  // pulse_at > 0 raises start for one cycle after that edge to test it is ignored.
  task automatic scan_to_valid(input string tag, input logic [7:0] exp_word, input int pulse_at);
    for (int e = 1; e <= 16; e++) begin
      step();
      if (e == pulse_at) start = 1'b1;
      else start = 1'b0;
      if (e < 16) begin
        check({tag, "_novalid"}, valid, 1'b0);
        check({tag, "_s"}, s, e / 2);
        check({tag, "_busy"}, busy, 1'b1);
      end else begin
        check({tag, "_valid"}, valid, 1'b1);
        check({tag, "_data"}, data, exp_word);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    start  = 1'b0;
    abort  = 1'b0;
    ready  = 1'b1;
    i_vec  = 8'h00;
    #12;
    check("rst_s", s, 0);
    check("rst_data", data, 0);
    check("rst_valid", valid, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;
    step();

    // 1: basic scan, ready held high
    i_vec = 8'hA5;
    start = 1'b1;
    step();
    start = 1'b0;
    check("t1_busy0", busy, 1);
    check("t1_s0", s, 0);
    scan_to_valid("t1", 8'hA5, 0);
    step();
    check("t1_vdrop", valid, 0);
    check("t1_idle", busy, 0);
    check("t1_keep", data, 8'hA5);
    check("t1_s_idle", s, 0);

    // 2: consumer stalls for 5 clocks
    i_vec = 8'h3C;
    ready = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    scan_to_valid("t2", 8'h3C, 0);
    for (int k = 0; k < 5; k++) begin
      step();
      check("t2_hold_v", valid, 1);
      check("t2_hold_d", data, 8'h3C);
      check("t2_hold_b", busy, 1);
    end
    ready = 1'b1;
    step();
    check("t2_drop", valid, 0);
    check("t2_busy", busy, 0);

    // 3: back-to-back scan from HOLD
    i_vec = 8'h11;
    ready = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    scan_to_valid("t3a", 8'h11, 0);
    ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    i_vec = 8'hF0;
    check("t3_v", valid, 0);
    check("t3_s", s, 0);
    check("t3_busy", busy, 1);
    check("t3_dkeep", data, 8'h11);
    scan_to_valid("t3b", 8'hF0, 0);
    step();
    check("t3_drop", valid, 0);

    // 4: start re-pulsed mid-scan at s=3 is ignored
    i_vec = 8'h5A;
    start = 1'b1;
    step();
    start = 1'b0;
    scan_to_valid("t4", 8'h5A, 6);
    step();
    check("t4_drop", valid, 0);
    check("t4_idle", busy, 0);

    // 5: abort with start at s=3
    i_vec = 8'hFF;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int e = 1; e <= 6; e++) step();
    check("t5_s3", s, 3);
    abort = 1'b1;
    start = 1'b1;
    step();
    abort = 1'b0;
    start = 1'b0;
    check("t5_s", s, 0);
    check("t5_busy", busy, 0);
    check("t5_valid", valid, 0);
    check("t5_data", data, 8'h5A);
    for (int k = 0; k < 20; k++) begin
      step();
      check("t5_novalid", valid, 0);
    end
    check("t5_data_end", data, 8'h5A);

    // 6: asynchronous reset mid-scan at s=5
    i_vec = 8'hC3;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int e = 1; e <= 10; e++) step();
    check("t6_s5", s, 5);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_s", s, 0);
    check("t6_data", data, 0);
    check("t6_valid", valid, 0);
    check("t6_busy", busy, 0);
    step();
    #3;
    rst_n = 1'b1;
    step();
    check("t6_idle", busy, 0);
    start = 1'b1;
    step();
    start = 1'b0;
    scan_to_valid("t6", 8'hC3, 0);
    step();
    check("t6_drop", valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
